result_axis_tx: RTL and testbench
=================================

# result_axis_tx

Output-side AXI-Stream transmitter for the CNN inference engine. It captures one parallel vector of signed FC-layer results in a single cycle and serializes it as an 8-bit `m_axis` byte stream, asserting `tlast` on the final byte. It raises a one-cycle interrupt once the frame has fully drained. It mirrors the engine's 8-bit `s_axis` input port on the transmit side.

## Interface
- `NUM_OUT`, 16: number of result words per frame (≥2).
- `DATA_W`, 16: width of each signed result word; must be a multiple of 8.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  capture strobe for `i_data`.
- `i_data`  in  NUM_OUT*DATA_W  flattened results; word k is `i_data[k*DATA_W +: DATA_W]`.
- `o_ready`  out  1  high when a capture will be accepted (state IDLE).
- `o_drop`  out  1  one-cycle pulse: `i_valid` arrived while not ready; that vector is discarded.
- `m_axis_data`  out  8  stream byte.
- `m_axis_valid`  out  1  byte valid.
- `m_axis_last`  out  1  final byte of frame.
- `m_axis_ready`  in  1  downstream accept.
- `o_intr`  out  1  one-cycle pulse after the final handshake.

## Operation
- Reset values: `o_ready`=1; `m_axis_valid`, `m_axis_last`, `o_intr`, `o_drop`=0; `m_axis_data`=0. State is IDLE; byte counter is 0.
- States:
  - IDLE → SEND on `i_valid`, which registers `i_data` into the frame register.
  - SEND → DONE on the handshake of the last byte.
  - DONE → IDLE unconditionally (1 cycle); `o_intr`=1 in DONE.
- Byte order: word 0 first, then ascending index. Within each word, LSB byte first. `BPW = DATA_W/8`; the frame is `NUM_OUT*BPW` bytes (default 32).
- A byte transfers only when `m_axis_valid & m_axis_ready`. While `m_axis_valid` is high and ready is low, `m_axis_data` and `m_axis_last` are held stable. `m_axis_valid` never drops before the handshake.
- `m_axis_valid` is high continuously throughout SEND; there are no bubbles between beats.
- `m_axis_last`=1 only during the final byte of the frame.
- `i_valid` in SEND or DONE: the vector is ignored, the frame register is unchanged, and `o_drop` pulses the next cycle.
- Reset mid-frame: the frame is abandoned. Next cycle all outputs are at reset values. No `o_intr` or `tlast` is issued for the aborted frame.
- A capture is accepted in IDLE in the cycle right after DONE. The minimum frame period is therefore frame bytes + 2 cycles.

## Timing
- `i_valid` sampled in IDLE at edge N → `m_axis_valid`=1 with byte 0 after edge N (visible in cycle N+1).
- With `m_axis_ready` held high: byte b is presented in cycle N+1+b. The last handshake happens in cycle N+NUM_OUT*BPW. `o_intr` is high in the following cycle. `o_ready` returns the cycle after that.
- `o_ready` is registered (equals state==IDLE); it is not combinational on `i_valid`.
- `o_drop` has one-cycle latency from the offending `i_valid`.

## Configuration
- `RESULT_ARGMAX_EN` defined:
  - Frame length is `NUM_OUT*BPW + 1`. After the last result byte, one extra byte is sent carrying the index (zero-extended, 8 bits) of the largest signed word.
  - On ties, the lowest index wins (strict greater-than compare).
  - `m_axis_last` moves to this class byte.
  - Argmax is computed sequentially during SEND (one word compared per word sent). It must be final before the class byte is presented; there is no extra bubble.
- Not defined: no class byte, no compare logic, and `tlast` is on the final result byte.

## Test plan
- Reset, then capture words k = 0x0100+k with `m_axis_ready`=1 → 32 bytes 00,01,01,01,02,01,…,0F,01 on consecutive cycles; `tlast` only on byte 31; `o_intr` pulses once, one cycle after it.
- Same frame with `m_axis_ready` toggling 1,0,0,1… → identical byte sequence, data stable during stalls, no lost or duplicated bytes.
- `i_valid` pulsed in mid-SEND with different data → `o_drop`=1 for one cycle; the transmitted frame still carries the original data.
- Assert `i_rst` after byte 10 → next cycle `m_axis_valid`=0, `o_ready`=1, no `o_intr`. A fresh capture then restarts from byte 0.
- `RESULT_ARGMAX_EN`: words all 0xFFF0 except word 5=0x0003 and word 9=0x0003 → 33 bytes; byte 32=0x05 with `tlast`.
- `RESULT_ARGMAX_EN`: all words 0x8000 → class byte 0x00.

Source files
------------

// File: rtl/result_axis_tx_if.sv
// ---------------------------------------------------------------------------
// result_axis_tx_if
// Byte-wide AXI-Stream bundle used on the result transmit side.
//   data  : stream byte
//   valid : byte valid
//   last  : final byte of frame
//   ready : downstream accept
// Modports: master (transmitter side), slave (receiver side).
// ---------------------------------------------------------------------------
interface result_axis_tx_if;
   logic [7:0] data;
   logic       valid;
   logic       last;
   logic       ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/result_axis_tx.sv
// ---------------------------------------------------------------------------
// result_axis_tx
// Captures one parallel vector of NUM_OUT signed DATA_W-bit results in a
// single cycle and serialises it as a byte stream (word 0 first, LSB byte
// first within each word), raising last on the final byte and a one-cycle
// interrupt once the frame has drained.
//
// Ports
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_valid      : capture strobe for i_data (accepted only while o_ready)
//   i_data       : flattened results, word k = i_data[k*DATA_W +: DATA_W]
//   o_ready      : high in IDLE (capture will be accepted)
//   o_drop       : one-cycle pulse, i_valid seen while busy (vector dropped)
//   o_intr       : one-cycle pulse the cycle after the last handshake
//   m_axis       : byte stream master (data/valid/last out, ready in)
//
// Optional feature macro: RESULT_ARGMAX_EN
//   When defined, one extra class byte carrying the index of the largest
//   signed word (lowest index on ties) follows the result bytes and carries
//   last. The argmax is built up one word per word sent.
// ---------------------------------------------------------------------------
module result_axis_tx #(
   parameter int unsigned NUM_OUT = 16,
   parameter int unsigned DATA_W  = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_valid,
   input  logic [NUM_OUT*DATA_W-1:0] i_data,
   output logic                      o_ready,
   output logic                      o_drop,
   output logic                      o_intr,
   result_axis_tx_if.master          m_axis
);

   localparam int unsigned BPW       = DATA_W / 8;
   localparam int unsigned RES_BYTES = NUM_OUT * BPW;
`ifdef RESULT_ARGMAX_EN
   localparam int unsigned FRAME_BYTES = RES_BYTES + 1;
`else
   localparam int unsigned FRAME_BYTES = RES_BYTES;
`endif
   localparam int unsigned CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [NUM_OUT*DATA_W-1:0] frame_q, frame_d;
   logic                      drop_q, drop_d;

   logic                      send;
   logic                      hs;
   logic [7:0]                byte_sel;

   assign send = (state_q == S_SEND);
   assign hs   = send & m_axis.ready;

`ifdef RESULT_ARGMAX_EN
   localparam int unsigned SUB_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned WRD_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(BPW - 1);
   localparam logic [CNT_W-1:0] CLASS_CNT = CNT_W'(RES_BYTES);

   logic [SUB_W-1:0]         sub_q, sub_d;
   logic [WRD_W-1:0]         wrd_q, wrd_d;
   logic signed [DATA_W-1:0] max_q, max_d;
   logic [WRD_W-1:0]         idx_q, idx_d;

   // The frame register shifts out one byte per handshake, so at the first
   // byte of each word its low DATA_W bits hold that whole word. Compare
   // there; a strict greater-than keeps the lowest index on ties. Word 0
   // seeds the running max at capture, so the last word is folded in during
   // its own bytes, well before the class byte is presented.
   always_comb begin
      sub_d = sub_q;
      wrd_d = wrd_q;
      max_d = max_q;
      idx_d = idx_q;
      if ((state_q == S_IDLE) && i_valid) begin
         sub_d = '0;
         wrd_d = '0;
         max_d = i_data[DATA_W-1:0];
         idx_d = '0;
      end else if (hs && (cnt_q < CLASS_CNT)) begin
         if ((sub_q == '0) && ($signed(frame_q[DATA_W-1:0]) > max_q)) begin
            max_d = frame_q[DATA_W-1:0];
            idx_d = wrd_q;
         end
         if (sub_q == SUB_LAST) begin
            sub_d = '0;
            wrd_d = wrd_q + WRD_W'(1);
         end else begin
            sub_d = sub_q + SUB_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sub_q <= '0;
         wrd_q <= '0;
         max_q <= '0;
         idx_q <= '0;
      end else begin
         sub_q <= sub_d;
         wrd_q <= wrd_d;
         max_q <= max_d;
         idx_q <= idx_d;
      end
   end

   assign byte_sel = (cnt_q == CLASS_CNT) ? 8'(idx_q) : frame_q[7:0];
`else
   assign byte_sel = frame_q[7:0];
`endif

   // Next-state and frame/counter update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      drop_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               state_d = S_SEND;
               cnt_d   = '0;
               frame_d = i_data;
            end
         end
         S_SEND: begin
            drop_d = i_valid;
            if (hs) begin
               frame_d = frame_q >> 8;
               if (cnt_q == LAST_CNT) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            drop_d  = i_valid;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         frame_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         drop_q  <= drop_d;
      end
   end

   // All outputs decode registered state only; data and last stay stable
   // through a stall because cnt_q/frame_q move only on a handshake.
   assign o_ready      = (state_q == S_IDLE);
   assign o_intr       = (state_q == S_DONE);
   assign o_drop       = drop_q;
   assign m_axis.valid = send;
   assign m_axis.last  = send && (cnt_q == LAST_CNT);
   assign m_axis.data  = send ? byte_sel : '0;

endmodule

// File: tb/tb_result_axis_tx.sv
module tb_result_axis_tx;

   localparam int NUM_OUT = 16;
   localparam int DATA_W  = 16;
   localparam int RES_B   = NUM_OUT * DATA_W / 8;
`ifdef RESULT_ARGMAX_EN
   localparam int FB = RES_B + 1;
`else
   localparam int FB = RES_B;
`endif

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      i_valid;
   logic [NUM_OUT*DATA_W-1:0] i_data;
   logic                      o_ready;
   logic                      o_drop;
   logic                      o_intr;

   result_axis_tx_if m_axis ();

   result_axis_tx #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_ready (o_ready),
      .o_drop  (o_drop),
      .o_intr  (o_intr),
      .m_axis  (m_axis.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_w [NUM_OUT];
   logic [7:0]  exp_cls;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int b);
      logic [15:0] w;
      if (b >= RES_B) return exp_cls;
      w = exp_w[b / 2];
      return (b % 2 == 1) ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [NUM_OUT*DATA_W-1:0] pack_words();
      logic [NUM_OUT*DATA_W-1:0] p;
      for (int k = 0; k < NUM_OUT; k++) p[k*DATA_W +: DATA_W] = exp_w[k];
      return p;
   endfunction

   task automatic capture();
      check("ready_before_capture", 32'(o_ready), 32'd1);
      i_data  = pack_words();
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   // Receives one frame. stall=1 uses ready pattern 1,0,0,1,0,0...
   // drop_cyc >= 0 pulses i_valid with foreign data in that cycle.
   task automatic recv(input string name, input bit stall, input int drop_cyc);
      int b = 0;
      int cyc = 0;
      logic rdy;
      while (b < FB && cyc < 400) begin
         rdy = stall ? (cyc % 3 == 0) : 1'b1;
         m_axis.ready = rdy;
         i_valid = (cyc == drop_cyc);
         i_data  = (cyc == drop_cyc) ? ~pack_words() : pack_words();
         check($sformatf("%s_valid_c%0d", name, cyc), 32'(m_axis.valid), 32'd1);
         check($sformatf("%s_data_b%0d", name, b), 32'(m_axis.data), 32'(exp_byte(b)));
         check($sformatf("%s_last_b%0d", name, b), 32'(m_axis.last), 32'(b == FB - 1));
         check($sformatf("%s_intr_c%0d", name, cyc), 32'(o_intr), 32'd0);
         check($sformatf("%s_drop_c%0d", name, cyc), 32'(o_drop), 32'(drop_cyc >= 0 && cyc == drop_cyc + 1));
         tick();
         if (rdy) b++;
         cyc++;
      end
      i_valid = 1'b0;
      m_axis.ready = 1'b1;
      check({name, "_completed"}, 32'(b), 32'(FB));
      check({name, "_intr_pulse"}, 32'(o_intr), 32'd1);
      check({name, "_valid_in_done"}, 32'(m_axis.valid), 32'd0);
      check({name, "_ready_in_done"}, 32'(o_ready), 32'd0);
      tick();
      check({name, "_intr_cleared"}, 32'(o_intr), 32'd0);
      check({name, "_ready_back"}, 32'(o_ready), 32'd1);
      check({name, "_data_idle"}, 32'(m_axis.data), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      i_valid = 1'b0;
      i_data = '0;
      m_axis.ready = 1'b1;
      tick();
      tick();
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_valid", 32'(m_axis.valid), 32'd0);
      check("rst_last", 32'(m_axis.last), 32'd0);
      check("rst_intr", 32'(o_intr), 32'd0);
      check("rst_drop", 32'(o_drop), 32'd0);
      check("rst_data", 32'(m_axis.data), 32'd0);
      rst = 1'b0;
      tick();

      // Ascending words 0x0100+k: bytes 00,01,01,01,02,01,...; argmax = 15.
      for (int k = 0; k < NUM_OUT; k++) exp_w[k] = 16'h0100 + 16'(k);
      exp_cls = 8'h0F;
      capture();
      recv("full", 1'b0, -1);

      capture();
      recv("stall", 1'b1, -1);

      capture();
      recv("drop", 1'b0, 7);

      // Abort after byte 10 has been accepted.
      capture();
      for (int b = 0; b < 11; b++) begin
         check($sformatf("abort_data_b%0d", b), 32'(m_axis.data), 32'(exp_byte(b)));
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_valid", 32'(m_axis.valid), 32'd0);
      check("abort_ready", 32'(o_ready), 32'd1);
      check("abort_intr", 32'(o_intr), 32'd0);
      check("abort_last", 32'(m_axis.last), 32'd0);
      check("abort_data", 32'(m_axis.data), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("abort_no_intr_c%0d", c), 32'(o_intr), 32'd0);
         check($sformatf("abort_idle_c%0d", c), 32'(m_axis.valid), 32'd0);
      end
      capture();
      recv("restart", 1'b0, -1);

`ifdef RESULT_ARGMAX_EN
      for (int k = 0; k < NUM_OUT; k++) exp_w[k] = 16'hFFF0;
      exp_w[5] = 16'h0003;
      exp_w[9] = 16'h0003;
      exp_cls  = 8'h05;
      capture();
      recv("argmax_tie", 1'b0, -1);

      for (int k = 0; k < NUM_OUT; k++) exp_w[k] = 16'h8000;
      exp_cls = 8'h00;
      capture();
      recv("argmax_allmin", 1'b1, -1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
